// File: rtl/wb_down_64to32.sv
// ============================================================================
// Module   : wb_down_64to32
// Purpose  : Wishbone classic down-converter, 64-bit upstream slave port to a
//            32-bit downstream slave. Each upstream cycle becomes one or two
//            32-bit single cycles (low word first); read data is reassembled
//            and a single ACK/ERR/RTY is returned upstream. All responses and
//            downstream controls are registered.
// Options  : define WB_DOWN_TIMEOUT_EN to abort a downstream beat with ERR
//            after TIMEOUT_CYC wait cycles without a response.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module wb_down_64to32 #(
    parameter int AW          = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          S_CYC_I,
    input  logic          S_STB_I,
    input  logic          S_WE_I,
    input  logic [63:0]   S_ADR_I,
    input  logic [7:0]    S_SEL_I,
    input  logic [63:0]   S_DAT_I,
    output logic [63:0]   S_DAT_O,
    output logic          S_ACK_O,
    output logic          S_ERR_O,
    output logic          S_RTY_O,
    output logic          M_CYC_O,
    output logic          M_STB_O,
    output logic          M_WE_O,
    output logic [AW-1:0] M_ADR_O,
    output logic [3:0]    M_SEL_O,
    output logic [31:0]   M_DAT_O,
    input  logic [31:0]   M_DAT_I,
    input  logic          M_ACK_I,
    input  logic          M_ERR_I,
    input  logic          M_RTY_I
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        RESP = 2'd3
    } state_t;

    // Clearing the low three bits gives the 64-bit word base; OR-ing 4 selects the high word.
    localparam logic [AW-1:0] c_BEAT_MASK = ~(AW'(7));
    localparam logic [AW-1:0] c_HI_OFS    = AW'(4);
    localparam logic [7:0]    c_TO_LAST   = 8'(TIMEOUT_CYC - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] adr_q, adr_d;
    logic          we_q, we_d;
    logic [7:0]    sel_q, sel_d;
    logic [63:0]   dat_q, dat_d;
    logic [63:0]   rdata_q, rdata_d;
    logic          m_cyc_q, m_cyc_d;
    logic          m_stb_q, m_stb_d;
    logic          m_we_q, m_we_d;
    logic [AW-1:0] m_adr_q, m_adr_d;
    logic [3:0]    m_sel_q, m_sel_d;
    logic [31:0]   m_dat_q, m_dat_d;
    logic          s_ack_q, s_ack_d;
    logic          s_err_q, s_err_d;
    logic          s_rty_q, s_rty_d;
    logic [AW-1:0] w_adr_base;
`ifdef WB_DOWN_TIMEOUT_EN
    logic [7:0]    cnt_q, cnt_d;
    wire           w_unused = &{1'b0, S_ADR_I};
`else
    wire           w_unused = &{1'b0, c_TO_LAST, S_ADR_I};
`endif

    assign w_adr_base = S_ADR_I[AW-1:0] & c_BEAT_MASK;

    // Next-state, downstream beat setup and upstream response generation.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        we_d    = we_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        rdata_d = rdata_q;
        m_cyc_d = m_cyc_q;
        m_stb_d = m_stb_q;
        m_we_d  = m_we_q;
        m_adr_d = m_adr_q;
        m_sel_d = m_sel_q;
        m_dat_d = m_dat_q;
        s_ack_d = 1'b0;
        s_err_d = 1'b0;
        s_rty_d = 1'b0;
`ifdef WB_DOWN_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                m_cyc_d = 1'b0;
                m_stb_d = 1'b0;
`ifdef WB_DOWN_TIMEOUT_EN
                cnt_d   = 8'd0;
`endif
                if (S_CYC_I && S_STB_I) begin
                    adr_d   = w_adr_base;
                    we_d    = S_WE_I;
                    sel_d   = S_SEL_I;
                    dat_d   = S_DAT_I;
                    rdata_d = 64'd0;
                    m_we_d  = S_WE_I;
                    if (S_SEL_I[3:0] != 4'h0) begin
                        state_d = LO;
                        m_cyc_d = 1'b1;
                        m_stb_d = 1'b1;
                        m_adr_d = w_adr_base;
                        m_sel_d = S_SEL_I[3:0];
                        m_dat_d = S_DAT_I[31:0];
                    end else if (S_SEL_I[7:4] != 4'h0) begin
                        state_d = HI;
                        m_cyc_d = 1'b1;
                        m_stb_d = 1'b1;
                        m_adr_d = w_adr_base | c_HI_OFS;
                        m_sel_d = S_SEL_I[7:4];
                        m_dat_d = S_DAT_I[63:32];
                    end else begin
                        // Nothing selected: acknowledge without touching the downstream bus.
                        state_d = RESP;
                        s_ack_d = 1'b1;
                    end
                end
            end
            LO, HI: begin
                if (!S_CYC_I) begin
                    // Upstream abandoned the cycle: release the bus, no response.
                    state_d = IDLE;
                    m_cyc_d = 1'b0;
                    m_stb_d = 1'b0;
                end else if (!m_stb_q) begin
                    // Idle strobe cycle between beats; present the high beat next.
                    m_stb_d = 1'b1;
`ifdef WB_DOWN_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                end else if (M_ERR_I) begin
                    state_d = RESP;
                    s_err_d = 1'b1;
                    m_cyc_d = 1'b0;
                    m_stb_d = 1'b0;
                end else if (M_RTY_I) begin
                    state_d = RESP;
                    s_rty_d = 1'b1;
                    m_cyc_d = 1'b0;
                    m_stb_d = 1'b0;
                end else if (M_ACK_I) begin
                    if (state_q == LO) begin
                        if (!we_q) rdata_d[31:0] = M_DAT_I;
                        if (sel_q[7:4] != 4'h0) begin
                            state_d = HI;
                            m_stb_d = 1'b0;
                            m_adr_d = adr_q | c_HI_OFS;
                            m_sel_d = sel_q[7:4];
                            m_dat_d = dat_q[63:32];
                        end else begin
                            state_d = RESP;
                            s_ack_d = 1'b1;
                            m_cyc_d = 1'b0;
                            m_stb_d = 1'b0;
                        end
                    end else begin
                        if (!we_q) rdata_d[63:32] = M_DAT_I;
                        state_d = RESP;
                        s_ack_d = 1'b1;
                        m_cyc_d = 1'b0;
                        m_stb_d = 1'b0;
                    end
                end
`ifdef WB_DOWN_TIMEOUT_EN
                else if (cnt_q == c_TO_LAST) begin
                    state_d = RESP;
                    s_err_d = 1'b1;
                    m_cyc_d = 1'b0;
                    m_stb_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; asynchronous reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            adr_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= 8'd0;
            dat_q   <= 64'd0;
            rdata_q <= 64'd0;
            m_cyc_q <= 1'b0;
            m_stb_q <= 1'b0;
            m_we_q  <= 1'b0;
            m_adr_q <= '0;
            m_sel_q <= 4'd0;
            m_dat_q <= 32'd0;
            s_ack_q <= 1'b0;
            s_err_q <= 1'b0;
            s_rty_q <= 1'b0;
`ifdef WB_DOWN_TIMEOUT_EN
            cnt_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            rdata_q <= rdata_d;
            m_cyc_q <= m_cyc_d;
            m_stb_q <= m_stb_d;
            m_we_q  <= m_we_d;
            m_adr_q <= m_adr_d;
            m_sel_q <= m_sel_d;
            m_dat_q <= m_dat_d;
            s_ack_q <= s_ack_d;
            s_err_q <= s_err_d;
            s_rty_q <= s_rty_d;
`ifdef WB_DOWN_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign S_DAT_O = rdata_q;
    assign S_ACK_O = s_ack_q;
    assign S_ERR_O = s_err_q;
    assign S_RTY_O = s_rty_q;
    assign M_CYC_O = m_cyc_q;
    assign M_STB_O = m_stb_q;
    assign M_WE_O  = m_we_q;
    assign M_ADR_O = m_adr_q;
    assign M_SEL_O = m_sel_q;
    assign M_DAT_O = m_dat_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_down_64to32.sv
// ============================================================================
// Module   : tb_wb_down_64to32
// Purpose  : Directed self-checking bench for wb_down_64to32 with a
//            configurable 32-bit slave model and a downstream beat logger.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_wb_down_64to32;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          S_CYC_I = 1'b0, S_STB_I = 1'b0, S_WE_I = 1'b0;
    logic [63:0]   S_ADR_I = '0, S_DAT_I = '0;
    logic [7:0]    S_SEL_I = '0;
    logic [63:0]   S_DAT_O;
    logic          S_ACK_O, S_ERR_O, S_RTY_O;
    logic          M_CYC_O, M_STB_O, M_WE_O;
    logic [AW-1:0] M_ADR_O;
    logic [3:0]    M_SEL_O;
    logic [31:0]   M_DAT_O, M_DAT_I;
    logic          M_ACK_I, M_ERR_I, M_RTY_I;

    // Slave model controls
    logic          mute = 1'b0;
    logic          a_lo = 1'b1, a_hi = 1'b1, e_lo = 1'b0, e_hi = 1'b0, r_lo = 1'b0, r_hi = 1'b0;
    logic [31:0]   rd_lo = '0, rd_hi = '0;

    assign M_ACK_I = M_STB_O & ~mute & (M_ADR_O[2] ? a_hi : a_lo);
    assign M_ERR_I = M_STB_O & ~mute & (M_ADR_O[2] ? e_hi : e_lo);
    assign M_RTY_I = M_STB_O & ~mute & (M_ADR_O[2] ? r_hi : r_lo);
    assign M_DAT_I = M_ADR_O[2] ? rd_hi : rd_lo;

    wb_down_64to32 #(.AW(AW), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .S_CYC_I(S_CYC_I), .S_STB_I(S_STB_I), .S_WE_I(S_WE_I), .S_ADR_I(S_ADR_I),
        .S_SEL_I(S_SEL_I), .S_DAT_I(S_DAT_I), .S_DAT_O(S_DAT_O),
        .S_ACK_O(S_ACK_O), .S_ERR_O(S_ERR_O), .S_RTY_O(S_RTY_O),
        .M_CYC_O(M_CYC_O), .M_STB_O(M_STB_O), .M_WE_O(M_WE_O), .M_ADR_O(M_ADR_O),
        .M_SEL_O(M_SEL_O), .M_DAT_O(M_DAT_O), .M_DAT_I(M_DAT_I),
        .M_ACK_I(M_ACK_I), .M_ERR_I(M_ERR_I), .M_RTY_I(M_RTY_I)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int t0 = 0;
    int at_cyc = 0;
    int cyc_hi = 0;
    int stb_lo = 0;
    int nbeats = 0;
    logic [31:0] b_adr [8];
    logic [3:0]  b_sel [8];
    logic [31:0] b_dat [8];
    logic        b_we  [8];

    always @(posedge clk) cyc <= cyc + 1;

    // Log every downstream beat that completes (any response while strobing).
    always @(negedge clk) begin
        if (rst_n && M_STB_O && (M_ACK_I || M_ERR_I || M_RTY_I)) begin
            if (nbeats < 8) begin
                b_adr[nbeats] = M_ADR_O;
                b_sel[nbeats] = M_SEL_O;
                b_dat[nbeats] = M_DAT_O;
                b_we[nbeats]  = M_WE_O;
            end
            nbeats++;
        end
    end

    task automatic slave_cfg(input logic ael, input logic aeh, input logic eel, input logic eeh,
                             input logic rrl, input logic rrh);
        a_lo = ael; a_hi = aeh; e_lo = eel; e_hi = eeh; r_lo = rrl; r_hi = rrh; mute = 1'b0;
    endtask

    // Present a request just after a rising edge; returns at the falling edge of the accept cycle.
    task automatic drive_req(input logic we, input logic [63:0] adr, input logic [7:0] sel,
                             input logic [63:0] dat);
        @(posedge clk);
        #1;
        nbeats  = 0;
        S_CYC_I = 1'b1; S_STB_I = 1'b1; S_WE_I = we;
        S_ADR_I = adr;  S_SEL_I = sel;  S_DAT_I = dat;
        @(negedge clk);
        t0 = cyc;
    endtask

    // Wait for an upstream response; lat = -1 when none arrives within budget.
    task automatic wait_resp(input int budget, input bit drop, output int lat,
                             output logic [2:0] rsp, output logic [63:0] dat);
        bit found = 1'b0;
        lat = -1; rsp = 3'b000; dat = '0; cyc_hi = 0; stb_lo = 0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (S_ACK_O || S_ERR_O || S_RTY_O) begin
                found  = 1'b1;
                lat    = cyc - t0;
                at_cyc = cyc;
                rsp    = {S_ACK_O, S_ERR_O, S_RTY_O};
                dat    = S_DAT_O;
                if (drop) begin
                    S_CYC_I = 1'b0; S_STB_I = 1'b0;
                end
            end else begin
                if (M_CYC_O) cyc_hi++;
                if (M_CYC_O && !M_STB_O) stb_lo++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({S_ACK_O, S_ERR_O, S_RTY_O} !== 3'b000) begin errors++; $display("FAIL rst_resp got=%b exp=000", {S_ACK_O, S_ERR_O, S_RTY_O}); end
        checks++; if ({M_CYC_O, M_STB_O, M_WE_O} !== 3'b000) begin errors++; $display("FAIL rst_mctl got=%b exp=000", {M_CYC_O, M_STB_O, M_WE_O}); end
        checks++; if (S_DAT_O !== 64'd0) begin errors++; $display("FAIL rst_sdat got=%h exp=0", S_DAT_O); end
        checks++; if ({M_ADR_O, M_SEL_O, M_DAT_O} !== 68'd0) begin errors++; $display("FAIL rst_mbus got=%h exp=0", {M_ADR_O, M_SEL_O, M_DAT_O}); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_two_beats();
        int lat; logic [2:0] rsp; logic [63:0] d;
        slave_cfg(1, 1, 0, 0, 0, 0);
        drive_req(1'b1, 64'h100, 8'hFF, 64'h11223344_55667788);
        wait_resp(20, 1'b1, lat, rsp, d);
        checks++; if (rsp !== 3'b100) begin errors++; $display("FAIL wr2_rsp got=%b exp=100", rsp); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL wr2_lat got=%0d exp=4", lat); end
        checks++; if (nbeats !== 2) begin errors++; $display("FAIL wr2_beats got=%0d exp=2", nbeats); end
        checks++; if ({b_adr[0], b_sel[0], b_dat[0], b_we[0]} !== {32'h100, 4'hF, 32'h55667788, 1'b1}) begin errors++; $display("FAIL wr2_beat0 got=%h/%h/%h/%b exp=100/f/55667788/1", b_adr[0], b_sel[0], b_dat[0], b_we[0]); end
        checks++; if ({b_adr[1], b_sel[1], b_dat[1], b_we[1]} !== {32'h104, 4'hF, 32'h11223344, 1'b1}) begin errors++; $display("FAIL wr2_beat1 got=%h/%h/%h/%b exp=104/f/11223344/1", b_adr[1], b_sel[1], b_dat[1], b_we[1]); end
        checks++; if (cyc_hi !== 3) begin errors++; $display("FAIL wr2_cyc_hold got=%0d exp=3", cyc_hi); end
        checks++; if (stb_lo !== 1) begin errors++; $display("FAIL wr2_stb_gap got=%0d exp=1", stb_lo); end
        @(negedge clk);
        checks++; if (S_ACK_O !== 1'b0) begin errors++; $display("FAIL wr2_ack_pulse got=%b exp=0", S_ACK_O); end
    endtask

    task automatic test_read_hi_only();
        int lat; logic [2:0] rsp; logic [63:0] d;
        slave_cfg(1, 1, 0, 0, 0, 0);
        rd_lo = 32'h5555AAAA; rd_hi = 32'hCAFEF00D;
        drive_req(1'b0, 64'h208, 8'hF0, 64'd0);
        wait_resp(20, 1'b1, lat, rsp, d);
        checks++; if (rsp !== 3'b100) begin errors++; $display("FAIL rdhi_rsp got=%b exp=100", rsp); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL rdhi_lat got=%0d exp=2", lat); end
        checks++; if (d !== 64'hCAFEF00D_00000000) begin errors++; $display("FAIL rdhi_data got=%h exp=cafef00d00000000", d); end
        checks++; if ({nbeats[3:0], b_adr[0], b_sel[0], b_we[0]} !== {4'd1, 32'h20C, 4'hF, 1'b0}) begin errors++; $display("FAIL rdhi_beat got=%0d/%h/%h/%b exp=1/20c/f/0", nbeats, b_adr[0], b_sel[0], b_we[0]); end
    endtask

    task automatic test_read_two_beats();
        int lat; logic [2:0] rsp; logic [63:0] d;
        slave_cfg(1, 1, 0, 0, 0, 0);
        rd_lo = 32'hAABBCCDD; rd_hi = 32'h01234567;
        drive_req(1'b0, 64'h305, 8'h3C, 64'd0);
        wait_resp(20, 1'b1, lat, rsp, d);
        checks++; if (lat !== 4) begin errors++; $display("FAIL rd2_lat got=%0d exp=4", lat); end
        checks++; if (d !== 64'h01234567_AABBCCDD) begin errors++; $display("FAIL rd2_data got=%h exp=01234567aabbccdd", d); end
        checks++; if ({b_adr[0], b_sel[0], b_adr[1], b_sel[1]} !== {32'h300, 4'hC, 32'h304, 4'h3}) begin errors++; $display("FAIL rd2_beats got=%h/%h %h/%h exp=300/c 304/3", b_adr[0], b_sel[0], b_adr[1], b_sel[1]); end
    endtask

    task automatic test_err_low();
        int lat; logic [2:0] rsp; logic [63:0] d;
        slave_cfg(1, 1, 1, 0, 0, 0);
        rd_lo = 32'h12345678;
        drive_req(1'b0, 64'h800, 8'hFF, 64'd0);
        wait_resp(20, 1'b1, lat, rsp, d);
        checks++; if (rsp !== 3'b010) begin errors++; $display("FAIL errlo_rsp got=%b exp=010", rsp); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL errlo_lat got=%0d exp=2", lat); end
        checks++; if (d !== 64'd0) begin errors++; $display("FAIL errlo_data got=%h exp=0", d); end
        @(negedge clk);
        checks++; if ({S_ERR_O, S_ACK_O, nbeats[3:0]} !== {1'b0, 1'b0, 4'd1}) begin errors++; $display("FAIL errlo_after got=%b%b/%0d exp=00/1", S_ERR_O, S_ACK_O, nbeats); end
    endtask

    task automatic test_sel_zero_and_rty();
        int lat; logic [2:0] rsp; logic [63:0] d;
        slave_cfg(1, 1, 0, 0, 0, 0);
        drive_req(1'b1, 64'hA00, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_resp(20, 1'b1, lat, rsp, d);
        checks++; if ({rsp, lat[3:0]} !== {3'b100, 4'd1}) begin errors++; $display("FAIL sel0_resp got=%b/%0d exp=100/1", rsp, lat); end
        checks++; if ({cyc_hi[3:0], nbeats[3:0]} !== 8'h00) begin errors++; $display("FAIL sel0_nobus got=%0d/%0d exp=0/0", cyc_hi, nbeats); end
        slave_cfg(1, 1, 0, 0, 0, 1);
        drive_req(1'b1, 64'hB00, 8'hFF, 64'h0102030405060708);
        wait_resp(20, 1'b1, lat, rsp, d);
        checks++; if ({rsp, lat[3:0]} !== {3'b001, 4'd4}) begin errors++; $display("FAIL rtyhi_resp got=%b/%0d exp=001/4", rsp, lat); end
        @(negedge clk);
        checks++; if ({S_RTY_O, nbeats[3:0]} !== {1'b0, 4'd2}) begin errors++; $display("FAIL rtyhi_after got=%b/%0d exp=0/2", S_RTY_O, nbeats); end
    endtask

    task automatic test_abort();
        int lat; logic [2:0] rsp; logic [63:0] d; int seen = 0;
        slave_cfg(1, 1, 0, 0, 0, 0);
        mute = 1'b1;
        drive_req(1'b0, 64'h500, 8'hFF, 64'd0);
        repeat (3) @(negedge clk);
        checks++; if ({M_CYC_O, M_STB_O} !== 2'b11) begin errors++; $display("FAIL abort_waiting got=%b exp=11", {M_CYC_O, M_STB_O}); end
        S_CYC_I = 1'b0; S_STB_I = 1'b0;
        mute = 1'b0;
        @(negedge clk);
        checks++; if ({M_CYC_O, M_STB_O} !== 2'b00) begin errors++; $display("FAIL abort_drop got=%b exp=00", {M_CYC_O, M_STB_O}); end
        if (S_ACK_O || S_ERR_O || S_RTY_O) seen++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (S_ACK_O || S_ERR_O || S_RTY_O) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_noresp got=%0d exp=0", seen); end
        drive_req(1'b1, 64'h40, 8'h0F, 64'hDEADBEEF_0BADF00D);
        wait_resp(20, 1'b1, lat, rsp, d);
        checks++; if ({rsp, lat[3:0], b_adr[0], b_dat[0]} !== {3'b100, 4'd2, 32'h40, 32'h0BADF00D}) begin errors++; $display("FAIL abort_next got=%b/%0d/%h/%h exp=100/2/40/0badf00d", rsp, lat, b_adr[0], b_dat[0]); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [2:0] rsp; logic [63:0] d; int at1;
        slave_cfg(1, 1, 0, 0, 0, 0);
        rd_lo = 32'h11111111;
        drive_req(1'b0, 64'h900, 8'h0F, 64'd0);
        wait_resp(20, 1'b0, lat, rsp, d);
        at1 = at_cyc;
        checks++; if (d !== 64'h00000000_11111111) begin errors++; $display("FAIL b2b_first got=%h exp=0000000011111111", d); end
        rd_lo = 32'h22222222;
        wait_resp(20, 1'b1, lat, rsp, d);
        checks++; if ((at_cyc - at1) !== 3) begin errors++; $display("FAIL b2b_spacing got=%0d exp=3", at_cyc - at1); end
        checks++; if ({rsp, d} !== {3'b100, 64'h00000000_22222222}) begin errors++; $display("FAIL b2b_second got=%b/%h exp=100/0000000022222222", rsp, d); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        slave_cfg(1, 1, 0, 0, 0, 0);
        mute = 1'b1;
        drive_req(1'b0, 64'h700, 8'hFF, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if ({M_CYC_O, M_STB_O} !== 2'b00) begin errors++; $display("FAIL rstmid_drop got=%b exp=00", {M_CYC_O, M_STB_O}); end
        S_CYC_I = 1'b0; S_STB_I = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mute = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (S_ACK_O || S_ERR_O || S_RTY_O || M_CYC_O) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_quiet got=%0d exp=0", seen); end
    endtask

    task automatic test_timeout();
        int lat; logic [2:0] rsp; logic [63:0] d;
        slave_cfg(1, 1, 0, 0, 0, 0);
        mute = 1'b1;
        drive_req(1'b1, 64'h600, 8'hFF, 64'h0);
`ifdef WB_DOWN_TIMEOUT_EN
        wait_resp(20, 1'b1, lat, rsp, d);
        checks++; if ({rsp, lat[3:0]} !== {3'b010, 4'd5}) begin errors++; $display("FAIL timeout_err got=%b/%0d exp=010/5", rsp, lat); end
        checks++; if ({M_CYC_O, M_STB_O} !== 2'b00) begin errors++; $display("FAIL timeout_drop got=%b exp=00", {M_CYC_O, M_STB_O}); end
`else
        wait_resp(1000, 1'b1, lat, rsp, d);
        checks++; if (lat !== -1) begin errors++; $display("FAIL nowait_resp got=%0d exp=-1", lat); end
        checks++; if ({M_CYC_O, M_STB_O} !== 2'b11) begin errors++; $display("FAIL nowait_hold got=%b exp=11", {M_CYC_O, M_STB_O}); end
        S_CYC_I = 1'b0; S_STB_I = 1'b0;
        @(negedge clk);
        checks++; if (M_CYC_O !== 1'b0) begin errors++; $display("FAIL nowait_release got=%b exp=0", M_CYC_O); end
`endif
        S_CYC_I = 1'b0; S_STB_I = 1'b0;
        mute = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write_two_beats();
        test_read_hi_only();
        test_read_two_beats();
        test_err_low();
        test_sel_zero_and_rty();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
